// File: rtl/plane_pkg.sv
// Shared types and constants for the plane scheduler: FSM states, screen
// geometry, coordinate widths and the per-slot record.
package plane_pkg;

    localparam int NUM_SLOTS    = 10;
    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int SPAWN_Y_BASE = 16;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SPAWN,
        DONE
    } state_e;

    typedef struct packed {
        logic           active;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } slot_t;

endpackage

// File: rtl/plane_scheduler_if.sv
// Bundle of the difficulty, hit, read and status signals of plane_scheduler.
// master drives the controls (game/VGA side), slave is the scheduler itself.
interface plane_scheduler_if;
    import plane_pkg::*;

    logic                 enable;
    logic                 frame_tick;
    logic [3:0]           plane_amount;
    logic [1:0]           flying_rate;
    logic                 hit_valid;
    logic [IDX_W-1:0]     hit_index;
    logic [IDX_W-1:0]     rd_index;
    logic [X_W-1:0]       rd_x;
    logic [Y_W-1:0]       rd_y;
    logic                 rd_active;
    logic [NUM_SLOTS-1:0] active_mask;
    logic                 busy;
    logic                 update_done;
    logic                 overrun;
    logic [7:0]           escaped;

    modport master (
        output enable, frame_tick, plane_amount, flying_rate,
        output hit_valid, hit_index, rd_index,
        input  rd_x, rd_y, rd_active, active_mask,
        input  busy, update_done, overrun, escaped
    );

    modport slave (
        input  enable, frame_tick, plane_amount, flying_rate,
        input  hit_valid, hit_index, rd_index,
        output rd_x, rd_y, rd_active, active_mask,
        output busy, update_done, overrun, escaped
    );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] value
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/plane_scheduler.sv
// Per-frame plane mover/spawner over a register array of plane slots.
// Define PLANE_SCHED_ESCAPE_CNT_EN to build the saturating escape counter.
module plane_scheduler
    import plane_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    plane_scheduler_if.slave bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [2:0]       step_q, step_d;
    logic [IDX_W-1:0] target_q, target_d;
    logic             overrun_q, overrun_d;
    slot_t            slots_q [NUM_SLOTS];
    slot_t            slots_d [NUM_SLOTS];
    slot_t            rd_q, rd_d;

    logic [7:0]       lfsr_val;
    logic             escape_inc;
    logic [IDX_W-1:0] active_cnt, free_idx;
    logic             free_found;
    logic [X_W:0]     x_sum;

    lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .value  (lfsr_val)
    );

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        active_cnt = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            active_cnt = active_cnt + IDX_W'(slots_q[i].active);
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        step_d     = step_q;
        target_d   = target_q;
        overrun_d  = overrun_q;
        slots_d    = slots_q;
        escape_inc = 1'b0;
        x_sum      = '0;

        case (state_q)
            IDLE: begin
                if (bus.frame_tick && bus.enable) begin
                    step_d   = {1'b0, bus.flying_rate} + 3'd1;
                    target_d = (bus.plane_amount > IDX_W'(NUM_SLOTS)) ?
                               IDX_W'(NUM_SLOTS) : bus.plane_amount;
                    ptr_d    = '0;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                if (slots_q[ptr_q].active) begin
                    x_sum = {1'b0, slots_q[ptr_q].x} + (X_W+1)'(step_q);
                    if (x_sum >= (X_W+1)'(SCREEN_W)) begin
                        slots_d[ptr_q].active = 1'b0;
                        escape_inc            = 1'b1;
                    end else begin
                        slots_d[ptr_q].x = x_sum[X_W-1:0];
                    end
                end
                if (ptr_q == IDX_W'(NUM_SLOTS - 1)) state_d = SPAWN;
                else                                ptr_d   = ptr_q + 1'b1;
            end
            SPAWN: begin
                if (free_found && (active_cnt < target_q)) begin
                    slots_d[free_idx] = '{active: 1'b1, x: '0,
                                          y: Y_W'(SPAWN_Y_BASE) + Y_W'(lfsr_val[5:0])};
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.frame_tick && bus.enable && (state_q != IDLE)) overrun_d = 1'b1;

        // Applied last so a retire beats a same-cycle MOVE/SPAWN write.
        if (bus.hit_valid && (bus.hit_index < IDX_W'(NUM_SLOTS))) begin
            slots_d[bus.hit_index].active = 1'b0;
        end

        rd_d = '0;
        if (bus.rd_index < IDX_W'(NUM_SLOTS)) rd_d = slots_d[bus.rd_index];
    end

    // NOTE: the slot array is flop-based and must be reset, since a stale
    // active bit would draw and move a phantom plane after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            step_q    <= '0;
            target_q  <= '0;
            overrun_q <= 1'b0;
            slots_q   <= '{default: '0};
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            step_q    <= step_d;
            target_q  <= target_d;
            overrun_q <= overrun_d;
            slots_q   <= slots_d;
            rd_q      <= rd_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_mask
        assign bus.active_mask[g] = slots_q[g].active;
    end

    assign bus.rd_x        = rd_q.x;
    assign bus.rd_y        = rd_q.y;
    assign bus.rd_active   = rd_q.active;
    assign bus.busy        = (state_q != IDLE);
    assign bus.update_done = (state_q == DONE);
    assign bus.overrun     = overrun_q;

`ifdef PLANE_SCHED_ESCAPE_CNT_EN
    logic [7:0] escaped_q, escaped_d;

    always_comb begin
        escaped_d = escaped_q;
        if (escape_inc && (escaped_q != 8'hFF)) escaped_d = escaped_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) escaped_q <= '0;
        else         escaped_q <= escaped_d;
    end

    assign bus.escaped = escaped_q;

    logic unused_bits;
    assign unused_bits = ^lfsr_val[7:6];
`else
    assign bus.escaped = 8'd0;

    logic unused_bits;
    assign unused_bits = ^{lfsr_val[7:6], escape_inc};
`endif

endmodule

// File: tb/tb_plane_scheduler.sv
// Self-checking bench for plane_scheduler: frame vector table, a frame-level
// slot model feeding a scoreboard, and hand sequences for timing corners.
module tb_plane_scheduler;
    import plane_pkg::*;

`ifdef PLANE_SCHED_ESCAPE_CNT_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    plane_scheduler_if bus ();

    plane_scheduler dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        bit active;
        int x;
        int y;
    } mslot_t;

    typedef struct {
        logic [NUM_SLOTS-1:0] mask;
        int                   escaped;
        bit                   overrun;
    } exp_t;

    typedef struct {
        int                   amount;
        int                   rate;
        bit                   hit_en;
        int                   hit_idx;
        int                   hit_at;
        bit                   dbl;
        logic [NUM_SLOTS-1:0] exp_mask;
    } vec_t;

    mslot_t     m_slot [NUM_SLOTS];
    int         m_escaped;
    bit         m_overrun;
    logic [7:0] m_lfsr;
    exp_t       sb_q [$];
    vec_t       vecs [$];

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic logic [NUM_SLOTS-1:0] model_mask();
        logic [NUM_SLOTS-1:0] m;
        for (int i = 0; i < NUM_SLOTS; i++) m[i] = m_slot[i].active;
        return m;
    endfunction

    task automatic do_reset();
        resetn           = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.hit_valid    = 1'b0;
        bus.hit_index    = '0;
        bus.rd_index     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = '{0, 0, 0};
        m_escaped = 0;
        m_overrun = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One accepted frame: model the pass, push the expectation, drive the tick
    // (plus an optional hit and an optional extra tick) and check the result.
    task automatic run_frame(input int amount, input int rate, input bit hit_en,
                             input int hit_idx, input int hit_at, input bit dbl);
        int         step, target, cnt, lat;
        logic [7:0] l;
        exp_t       e;
        @(negedge clk);
        step   = rate + 1;
        target = (amount > NUM_SLOTS) ? NUM_SLOTS : amount;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_slot[i].active) begin
                if (m_slot[i].x + step >= SCREEN_W) begin
                    m_slot[i].active = 1'b0;
                    if (ESC_EN && m_escaped < 255) m_escaped++;
                end else begin
                    m_slot[i].x += step;
                end
            end
        end
        if (hit_en && hit_idx < NUM_SLOTS) m_slot[hit_idx].active = 1'b0;
        l = m_lfsr;
        repeat (11) l = lfsr_next(l);
        cnt = 0;
        for (int i = 0; i < NUM_SLOTS; i++) cnt += int'(m_slot[i].active);
        if (cnt < target) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!m_slot[i].active) begin
                    m_slot[i] = '{1'b1, 0, SPAWN_Y_BASE + int'(l[5:0])};
                    break;
                end
            end
        end
        if (dbl) m_overrun = 1'b1;
        e.mask    = model_mask();
        e.escaped = m_escaped;
        e.overrun = m_overrun;
        sb_q.push_back(e);

        bus.plane_amount = amount[3:0];
        bus.flying_rate  = rate[1:0];
        bus.frame_tick   = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        lat = 1;
        check("busy_start", bus.busy, 1);
        while (!bus.update_done && lat < 40) begin
            if (hit_en && hit_idx < NUM_SLOTS && lat == hit_at + 2)
                check("hit_visible", bus.active_mask[hit_idx], 0);
            bus.hit_valid  = hit_en && (lat == hit_at + 1);
            bus.hit_index  = hit_idx[3:0];
            bus.frame_tick = dbl && (lat == 5);
            @(negedge clk);
            lat++;
        end
        bus.hit_valid  = 1'b0;
        bus.frame_tick = 1'b0;
        check("done_latency", lat, 12);
        check("busy_at_done", bus.busy, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("frame_mask", bus.active_mask, e.mask);
            check("frame_escaped", bus.escaped, e.escaped);
            check("frame_overrun", bus.overrun, e.overrun);
        end
        @(negedge clk);
        check("busy_after", bus.busy, 0);
        check("done_single", bus.update_done, 0);
        if (dbl) begin
            repeat (2) @(negedge clk);
            check("dropped_tick_idle", bus.busy, 0);
        end
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.rd_index = 4'(i);
            @(negedge clk);
            check($sformatf("%s_act%0d", tag, i), bus.rd_active, m_slot[i].active);
            if (m_slot[i].active) begin
                check($sformatf("%s_x%0d", tag, i), bus.rd_x, m_slot[i].x);
                check($sformatf("%s_y%0d", tag, i), bus.rd_y, m_slot[i].y);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable       = 1'b1;
        bus.frame_tick   = 1'b0;
        bus.plane_amount = '0;
        bus.flying_rate  = '0;
        bus.hit_valid    = 1'b0;
        bus.hit_index    = '0;
        bus.rd_index     = '0;
        do_reset();
        @(negedge clk);

        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.update_done, 0);
        check("rst_mask", bus.active_mask, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_escaped", bus.escaped, 0);
        check("rst_rd_active", bus.rd_active, 0);
        check("rst_rd_x", bus.rd_x, 0);
        check("rst_rd_y", bus.rd_y, 0);

        // A tick with enable low is ignored and never flags an overrun.
        bus.enable       = 1'b0;
        bus.plane_amount = 4'd3;
        bus.frame_tick   = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_busy", bus.busy, 0);
        check("dis_overrun", bus.overrun, 0);
        check("dis_mask", bus.active_mask, 0);
        bus.enable = 1'b1;

        vecs.push_back('{3,  0, 1'b0, 0,  0, 1'b0, 10'h001});
        vecs.push_back('{3,  0, 1'b0, 0,  0, 1'b0, 10'h003});
        vecs.push_back('{3,  0, 1'b0, 0,  0, 1'b0, 10'h007});
        vecs.push_back('{3,  0, 1'b1, 1,  1, 1'b0, 10'h007});
        vecs.push_back('{3,  0, 1'b1, 12, 4, 1'b0, 10'h007});
        vecs.push_back('{2,  1, 1'b0, 0,  0, 1'b1, 10'h007});
        vecs.push_back('{0,  0, 1'b0, 0,  0, 1'b0, 10'h007});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h00F});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h01F});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h03F});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h07F});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h0FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h1FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{15, 0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{2,  0, 1'b0, 0,  0, 1'b0, 10'h3FF});
        vecs.push_back('{2,  0, 1'b0, 0,  0, 1'b0, 10'h3FF});

        foreach (vecs[k]) begin
            run_frame(vecs[k].amount, vecs[k].rate, vecs[k].hit_en,
                      vecs[k].hit_idx, vecs[k].hit_at, vecs[k].dbl);
            check($sformatf("vec%0d_mask", k), bus.active_mask, vecs[k].exp_mask);
            if (k == 2 || k == 3 || k == 20) check_slots($sformatf("vec%0d", k));
        end
        check("overrun_sticky", bus.overrun, 1);

        // Hit while idle with enable low still retires the slot.
        @(negedge clk);
        bus.enable    = 1'b0;
        bus.hit_valid = 1'b1;
        bus.hit_index = 4'd0;
        @(negedge clk);
        bus.hit_valid = 1'b0;
        m_slot[0].active = 1'b0;
        check("idle_hit_mask", bus.active_mask, 10'h3FE);
        bus.enable = 1'b1;
        check_slots("idle_hit");

        // Walk one plane to x=157, then step 4 carries it off screen.
        do_reset();
        run_frame(1, 3, 1'b0, 0, 0, 1'b0);
        for (int f = 0; f < 39; f++) run_frame(1, 3, 1'b0, 0, 0, 1'b0);
        run_frame(1, 0, 1'b0, 0, 0, 1'b0);
        check("pre_escape_x_model", m_slot[0].x, 157);
        check_slots("pre_escape");
        check("pre_escape_count", bus.escaped, 0);
        run_frame(1, 3, 1'b0, 0, 0, 1'b0);
        check("escape_count", bus.escaped, ESC_EN ? 1 : 0);
        check("escape_refill_mask", bus.active_mask, 10'h001);
        check_slots("post_escape");

        // Reset in the middle of a pass.
        @(negedge clk);
        bus.rd_index     = '0;
        bus.plane_amount = 4'd1;
        bus.flying_rate  = 2'd0;
        bus.frame_tick   = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", bus.busy, 1);
        check("mid_rd_active_before", bus.rd_active, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.update_done, 0);
        check("mid_rst_mask", bus.active_mask, 0);
        check("mid_rst_overrun", bus.overrun, 0);
        check("mid_rst_escaped", bus.escaped, 0);
        check("mid_rst_rd_active", bus.rd_active, 0);
        check("mid_rst_rd_x", bus.rd_x, 0);
        check("mid_rst_rd_y", bus.rd_y, 0);
        do_reset();
        repeat (3) @(negedge clk);
        check("post_rst_idle", bus.busy, 0);
        run_frame(1, 0, 1'b0, 0, 0, 1'b0);
        check("post_rst_mask", bus.active_mask, 10'h001);
        check_slots("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
